// File: rtl/uart_simplex_rx.sv
// Receive-only UART: 2-flop synchroniser, mid-bit sampling FSM, LSB-first deserialiser.
// Emits one-cycle o_VALID per good frame and one-cycle o_FRAME_ERR on a low stop bit.
module uart_simplex_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_RX,
  output logic [DATA_BITS-1:0] o_DATA,
  output logic                 o_VALID,
  output logic                 o_FRAME_ERR,
  output logic                 o_BUSY
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state, state_next;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr, cnt_inc, bit_clr, shift_en, valid_next, ferr_next;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) sync <= '1;
    else          sync <= {sync[0], i_RX};
  end
  assign rx_s = sync[1];

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_clr    = 1'b1;
          bit_clr    = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) state_next = STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch an immediately following start.
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_DATA      <= '0;
      o_VALID     <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + IW'(1);
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (valid_next) o_DATA <= shreg;
      o_VALID     <= valid_next;
      o_FRAME_ERR <= ferr_next;
    end
  end

  assign o_BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_simplex_rx.sv
// Scoreboarded bench for uart_simplex_rx: expected strobes are queued when frames are
// driven, observed strobes are captured on the falling clock edge and compared per task.
module tb_uart_simplex_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned DB  = 8;
  localparam int unsigned LAT = 2 + CPB / 2 + (DB + 1) * CPB;

  typedef struct {
    logic [DB-1:0] data;
    logic          err;
    logic          valid;
    int unsigned   cyc;
  } ev_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx    = 1'b1;
  logic [DB-1:0] o_data;
  logic          o_valid, o_ferr, o_busy;

  int unsigned   cyc        = 0;
  int unsigned   busy_total = 0;
  int            errors     = 0;
  int            checks     = 0;
  logic [DB-1:0] last_good  = '0;
  ev_t           exp_q[$];
  ev_t           obs_q[$];

  uart_simplex_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_RX       (rx),
    .o_DATA     (o_data),
    .o_VALID    (o_valid),
    .o_FRAME_ERR(o_ferr),
    .o_BUSY     (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid || o_ferr) obs_q.push_back('{o_data, o_ferr, o_valid, cyc});
    if (o_busy) busy_total = busy_total + 1;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a whole frame and queues the strobe the receiver should produce for it.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    int unsigned t0;
    rx = 1'b0;
    t0 = cyc + 1;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop;
    if (stop) begin
      exp_q.push_back('{d, 1'b0, 1'b1, t0 + LAT});
      last_good = d;
    end else begin
      exp_q.push_back('{last_good, 1'b1, 1'b0, t0 + LAT});
    end
    tick(CPB);
  endtask

  task automatic test_reset;
    int unsigned b0;
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 00", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
    checks++; if (o_ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", o_ferr); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    rst_n = 1'b1;
    b0 = busy_total;
    tick(200);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL idle_strobes: got %0d, required 0", obs_q.size()); end
    checks++; if (busy_total - b0 != 0) begin errors++; $display("FAIL idle_busy: got %0d busy cycles, required 0", busy_total - b0); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL idle_data: got %h, required 00", o_data); end
    obs_q.delete();
  endtask

  task automatic test_single;
    ev_t e, o;
    send_frame(8'hA5, 1'b1);
    tick(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL single_strobe: got none, required data=%h err=%b", e.data, e.err);
      end else begin
        o = obs_q.pop_front();
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL single_data: got %h, required %h", o.data, e.data); end
        checks++; if ({o.valid, o.err} !== {~e.err, e.err}) begin errors++; $display("FAIL single_flags: got valid/err=%b%b, required %b%b", o.valid, o.err, ~e.err, e.err); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL single_latency: got cycle %0d, required %0d", o.cyc, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra: got %0d extra strobes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    ev_t e, o;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL b2b_strobe: got none, required data=%h err=%b", e.data, e.err);
      end else begin
        o = obs_q.pop_front();
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL b2b_data: got %h, required %h", o.data, e.data); end
        checks++; if ({o.valid, o.err} !== {~e.err, e.err}) begin errors++; $display("FAIL b2b_flags: got valid/err=%b%b, required %b%b", o.valid, o.err, ~e.err, e.err); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL b2b_latency: got cycle %0d, required %0d", o.cyc, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra strobes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_glitch;
    int unsigned b0, d;
    b0 = busy_total;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    d = busy_total - b0;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_strobes: got %0d, required 0", obs_q.size()); end
    checks++; if (d < 1 || d > 10) begin errors++; $display("FAIL glitch_busy: got %0d busy cycles, required 1..10", d); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b, required 0", o_busy); end
    obs_q.delete();
  endtask

  task automatic test_frame_error;
    ev_t e, o;
    send_frame(8'h55, 1'b0);
    tick(50);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL break_hold: got busy=%b, required 1", o_busy); end
    checks++; if (o_data !== last_good) begin errors++; $display("FAIL ferr_data_hold: got %h, required %h", o_data, last_good); end
    rx = 1'b1;
    tick(5);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL break_exit: got busy=%b, required 0", o_busy); end
    tick(10);
    send_frame(8'h12, 1'b1);
    tick(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL ferr_strobe: got none, required data=%h err=%b", e.data, e.err);
      end else begin
        o = obs_q.pop_front();
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL ferr_data: got %h, required %h", o.data, e.data); end
        checks++; if ({o.valid, o.err} !== {~e.err, e.err}) begin errors++; $display("FAIL ferr_flags: got valid/err=%b%b, required %b%b", o.valid, o.err, ~e.err, e.err); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL ferr_latency: got cycle %0d, required %0d", o.cyc, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ferr_extra: got %0d extra strobes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    ev_t         e, o;
    logic [DB-1:0] abort_data;
    abort_data = 8'h0F;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = abort_data[i];
      tick(CPB);
    end
    rx = abort_data[4];
    tick(CPB / 2);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b, required 1", o_busy); end
    rst_n = 1'b0;
    #1;
    last_good = '0;
    checks++; if (o_data !== '0) begin errors++; $display("FAIL abort_data_clear: got %h, required 00", o_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_clear: got %b, required 0", o_busy); end
    rx = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(20);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL abort_strobes: got %0d, required 0", obs_q.size()); end
    obs_q.delete();
    send_frame(8'h81, 1'b1);
    tick(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL abort_next_strobe: got none, required data=%h err=%b", e.data, e.err);
      end else begin
        o = obs_q.pop_front();
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL abort_next_data: got %h, required %h", o.data, e.data); end
        checks++; if ({o.valid, o.err} !== {~e.err, e.err}) begin errors++; $display("FAIL abort_next_flags: got valid/err=%b%b, required %b%b", o.valid, o.err, ~e.err, e.err); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL abort_next_latency: got cycle %0d, required %0d", o.cyc, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL abort_next_extra: got %0d extra strobes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
